// File: rtl/cache_axi_bridge.sv
// rtl/cache_axi_bridge.sv - cache miss-side rd/wr requests to AXI4 master read/write transactions
//
// Ports:
//   clk, resetn                         clock, synchronous active-low reset
//   rd_req/rd_type/rd_addr/rd_rdy       cache read request (type 000/001/010 single, 100 line)
//   ret_valid/ret_last/ret_data         returned read words, ret_last[0] marks the final word
//   wr_req/wr_type/wr_addr/wr_wstrb/
//   wr_data/wr_rdy                      cache write request (line writeback or uncached store)
//   ar*/r*                              AXI4 read address and read data channels
//   aw*/w*/b*                           AXI4 write address, write data and write response channels
module cache_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic [1:0]   ret_last,
    output logic [31:0]  ret_data,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready,
    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic         awvalid,
    input  logic         awready,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic [3:0]   bid,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready
);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_B} wr_state_t;

    rd_state_t      rd_state;
    wr_state_t      wr_state;
    logic [127:0]   wbuf;
    logic [31:0]    wbuf_addr;
    logic [7:0]     w_len;
    logic [2:0]     w_size;
    logic [3:0]     w_strb;
    logic [1:0]     beat;
    logic           aw_done;
    logic           w_done;
    logic           hazard;
    logic           aw_fin;
    logic           w_fin;
    logic           unused;

    function automatic logic [7:0] len_of(input logic [2:0] t);
        return (t == 3'b100) ? 8'd3 : 8'd0;
    endfunction

    function automatic logic [2:0] size_of(input logic [2:0] t);
        return (t == 3'b100) ? 3'b010 : {1'b0, t[1:0]};
    endfunction

    // Line transfers always start at the line base; single transfers keep the byte address.
    function automatic logic [31:0] addr_of(input logic [2:0] t, input logic [31:0] a);
        return (t == 3'b100) ? {a[31:4], 4'b0000} : a;
    endfunction

    // A read of a line still sitting in the write buffer must wait for that write's B response,
    // otherwise the refill could return stale memory contents.
    assign hazard = (wr_state != W_IDLE) && (rd_addr[31:4] == wbuf_addr[31:4]);
    assign rd_rdy = (rd_state == R_IDLE) && !hazard;
    assign wr_rdy = (wr_state == W_IDLE);

    assign arid    = AXI_ID;
    assign arburst = 2'b01;
    assign awid    = AXI_ID;
    assign awburst = 2'b01;

    // Read data is forwarded straight to the cache with no added latency.
    assign ret_valid = (rd_state == R_DATA) && rvalid;
    assign ret_data  = rdata;
    assign ret_last  = {1'b0, ret_valid && rlast};

    assign awaddr = wbuf_addr;
    assign awlen  = w_len;
    assign awsize = w_size;
    assign wstrb  = w_strb;
    assign wdata  = wbuf[{beat, 5'b00000} +: 32];
    assign wlast  = (beat == w_len[1:0]);

    // AW and W complete independently; either may finish first or both in the same cycle.
    assign aw_fin = aw_done || (awvalid && awready);
    assign w_fin  = w_done || (wvalid && wready && wlast);

    assign unused = ^{rid, rresp, bid, bresp, w_len[7:2]};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_state <= R_IDLE;
            arvalid  <= 1'b0;
            rready   <= 1'b0;
            araddr   <= 32'd0;
            arlen    <= 8'd0;
            arsize   <= 3'd0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (rd_req && rd_rdy) begin
                        araddr   <= addr_of(rd_type, rd_addr);
                        arlen    <= len_of(rd_type);
                        arsize   <= size_of(rd_type);
                        arvalid  <= 1'b1;
                        rd_state <= R_AR;
                    end
                end
                R_AR: begin
                    if (arready) begin
                        arvalid  <= 1'b0;
                        rready   <= 1'b1;
                        rd_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid && rlast) begin
                        rready   <= 1'b0;
                        rd_state <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_state  <= W_IDLE;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            beat      <= 2'd0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            wbuf      <= 128'd0;
            wbuf_addr <= 32'd0;
            w_len     <= 8'd0;
            w_size    <= 3'd0;
            w_strb    <= 4'd0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (wr_req) begin
                        wbuf      <= wr_data;
                        wbuf_addr <= addr_of(wr_type, wr_addr);
                        w_len     <= len_of(wr_type);
                        w_size    <= size_of(wr_type);
                        w_strb    <= (wr_type == 3'b100) ? 4'hf : wr_wstrb;
                        beat      <= 2'd0;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        awvalid   <= 1'b1;
                        wvalid    <= 1'b1;
                        wr_state  <= W_REQ;
                    end
                end
                W_REQ: begin
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (wvalid && wready) begin
                        beat <= beat + 2'd1;
                        if (wlast) begin
                            wvalid <= 1'b0;
                            w_done <= 1'b1;
                        end
                    end
                    if (aw_fin && w_fin) begin
                        bready   <= 1'b1;
                        wr_state <= W_B;
                    end
                end
                W_B: begin
                    if (bvalid) begin
                        bready   <= 1'b0;
                        wr_state <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// tb/tb_cache_axi_bridge.sv - self-checking bench for cache_axi_bridge
module tb_cache_axi_bridge;

    logic         clk = 1'b0;
    logic         resetn;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic [1:0]   ret_last;
    logic [31:0]  ret_data;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [3:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cache_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rules for a request type.
    function automatic int beats_of(input logic [2:0] t);
        return (t == 3'b100) ? 4 : 1;
    endfunction

    function automatic logic [2:0] exp_size(input logic [2:0] t);
        if (t == 3'b100) return 3'd2;
        return {1'b0, t[1:0]};
    endfunction

    function automatic logic [31:0] exp_addr(input logic [2:0] t, input logic [31:0] a);
        return (t == 3'b100) ? (a & 32'hFFFF_FFF0) : a;
    endfunction

    task automatic issue_read(input logic [2:0] t, input logic [31:0] a);
        rd_type = t;
        rd_addr = a;
        rd_req  = 1'b1;
        #1;
        chk("rd_rdy_accept", rd_rdy, 1'b1);
        tick();
        rd_req = 1'b0;
        #1;
        chk("arvalid_up", arvalid, 1'b1);
        chk("araddr", araddr, exp_addr(t, a));
        chk("arlen", arlen, 8'(beats_of(t) - 1));
        chk("arsize", arsize, exp_size(t));
        chk("arburst", arburst, 2'b01);
        chk("arid", arid, 4'd1);
    endtask

    task automatic finish_read(input logic [2:0] t, input logic [31:0] a, input int ar_delay,
                               input int gap_max, input logic [31:0] base, input bit rnd);
        int n;
        logic [31:0] w;
        n = beats_of(t);
        for (int i = 0; i < ar_delay; i++) begin
            arready = 1'b0;
            tick();
            chk("arvalid_hold", arvalid, 1'b1);
            chk("araddr_stable", araddr, exp_addr(t, a));
            chk("arlen_stable", arlen, 8'(n - 1));
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        #1;
        chk("arvalid_drop", arvalid, 1'b0);
        chk("rready_up", rready, 1'b1);
        for (int i = 0; i < n; i++) begin
            int g;
            g = $urandom_range(gap_max, 0);
            for (int k = 0; k < g; k++) begin
                rvalid = 1'b0;
                rdata  = $urandom;
                #1;
                chk("ret_valid_gap", ret_valid, 1'b0);
                tick();
            end
            w      = rnd ? $urandom : base + 32'(i);
            rvalid = 1'b1;
            rdata  = w;
            rlast  = (i == n - 1);
            #1;
            chk("ret_valid", ret_valid, 1'b1);
            chk("ret_data", ret_data, w);
            chk("ret_last", ret_last, {1'b0, (i == n - 1) ? 1'b1 : 1'b0});
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        #1;
        chk("rready_drop", rready, 1'b0);
        chk("rd_rdy_after_last", rd_rdy, 1'b1);
    endtask

    // hz: read of hz_addr must be held off until after bvalid.
    // alt: a read of 0x00002000 is issued while the write waits for B.
    task automatic do_write(input logic [2:0] t, input logic [31:0] a, input logic [127:0] d,
                            input logic [3:0] s, input int aw_delay, input bit wrand,
                            input bit hz, input logic [31:0] hz_addr, input bit alt);
        int n;
        int beats;
        int cyc;
        bit aw_seen;
        logic [3:0] es;
        n       = beats_of(t);
        es      = (t == 3'b100) ? 4'hf : s;
        beats   = 0;
        cyc     = 0;
        aw_seen = 1'b0;
        wr_type  = t;
        wr_addr  = a;
        wr_wstrb = s;
        wr_data  = d;
        wr_req   = 1'b1;
        #1;
        chk("wr_rdy_accept", wr_rdy, 1'b1);
        tick();
        wr_req = 1'b0;
        #1;
        chk("wr_rdy_busy", wr_rdy, 1'b0);
        while (!(aw_seen && beats == n) && cyc < 60) begin
            awready = (cyc >= aw_delay);
            wready  = wrand ? 1'($urandom) : 1'b1;
            if (hz) rd_addr = hz_addr;
            #1;
            if (hz) chk("hazard_block", rd_rdy, 1'b0);
            chk("awvalid_hold", awvalid, !aw_seen);
            chk("wvalid_hold", wvalid, beats < n);
            if (awvalid) begin
                chk("awaddr", awaddr, exp_addr(t, a));
                chk("awlen", awlen, 8'(n - 1));
                chk("awsize", awsize, exp_size(t));
                chk("awburst", awburst, 2'b01);
                chk("awid", awid, 4'd1);
            end
            if (wvalid) begin
                chk("wdata", wdata, d[beats*32 +: 32]);
                chk("wstrb", wstrb, es);
                chk("wlast", wlast, beats == n - 1);
            end
            if (awvalid && awready) aw_seen = 1'b1;
            if (wvalid && wready) beats++;
            tick();
            cyc++;
        end
        awready = 1'b0;
        wready  = 1'b0;
        chk("write_timeout", cyc < 60, 1'b1);
        #1;
        chk("awvalid_done", awvalid, 1'b0);
        chk("wvalid_done", wvalid, 1'b0);
        chk("bready_up", bready, 1'b1);
        for (int k = 0; k < 2; k++) begin
            bvalid = 1'b0;
            if (alt && k == 0) begin
                rd_type = 3'b010;
                rd_addr = 32'h0000_2000;
                rd_req  = 1'b1;
                #1;
                chk("other_line_accept", rd_rdy, 1'b1);
            end else begin
                #1;
            end
            chk("wr_rdy_wait_b", wr_rdy, 1'b0);
            if (hz) chk("hazard_wait_b", rd_rdy, 1'b0);
            tick();
            rd_req = 1'b0;
        end
        bvalid = 1'b1;
        bresp  = 2'($urandom);
        #1;
        if (hz) chk("hazard_b_cycle", rd_rdy, 1'b0);
        tick();
        bvalid = 1'b0;
        #1;
        chk("wr_rdy_after_b", wr_rdy, 1'b1);
        chk("bready_drop", bready, 1'b0);
        if (hz) chk("hazard_release", rd_rdy, 1'b1);
    endtask

    initial begin
        logic [2:0] types [4];
        logic [2:0] t;
        logic [31:0] a;
        types = '{3'b000, 3'b001, 3'b010, 3'b100};

        resetn = 1'b0;
        rd_req = 1'b0; rd_type = 3'd0; rd_addr = 32'd0;
        wr_req = 1'b0; wr_type = 3'd0; wr_addr = 32'd0; wr_wstrb = 4'd0; wr_data = 128'd0;
        arready = 1'b0; rid = 4'd1; rdata = 32'd0; rresp = 2'd0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = 4'd1; bresp = 2'd0; bvalid = 1'b0;
        tick();
        tick();
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_bready", bready, 1'b0);
        chk("rst_ret_valid", ret_valid, 1'b0);
        chk("rst_rd_rdy", rd_rdy, 1'b1);
        chk("rst_wr_rdy", wr_rdy, 1'b1);
        resetn = 1'b1;
        tick();

        // Line refill read with words 0xA0..0xA3
        issue_read(3'b100, 32'h1C00_0120);
        finish_read(3'b100, 32'h1C00_0120, 0, 0, 32'hA0, 1'b0);

        // Uncached byte read
        issue_read(3'b000, 32'hBFAF_8001);
        finish_read(3'b000, 32'hBFAF_8001, 0, 0, 32'h5A, 1'b0);

        // Writeback with AW held off 5 cycles and a same-line read blocked until after B
        do_write(3'b100, 32'h0000_1230, {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000},
                 4'h0, 5, 1'b0, 1'b1, 32'h0000_1238, 1'b0);

        // Same writeback again; a different-line read goes out while B is pending
        do_write(3'b100, 32'h0000_1230, {$urandom, $urandom, $urandom, $urandom},
                 4'h0, 2, 1'b1, 1'b0, 32'h0, 1'b1);
        finish_read(3'b010, 32'h0000_2000, 1, 1, 32'h0, 1'b1);

        // Uncached word write with partial strobe
        do_write(3'b010, 32'h0000_3004, {96'h0, 32'hCAFE_F00D}, 4'b0110, 0, 1'b0, 1'b0, 32'h0, 1'b0);

        // AR backpressure and rvalid gaps
        issue_read(3'b100, 32'h0000_4444);
        finish_read(3'b100, 32'h0000_4444, 3, 2, 32'h0, 1'b1);

        // Randomized traffic against the reference rules
        for (int k = 0; k < 8; k++) begin
            t = types[$urandom_range(3, 0)];
            a = $urandom;
            issue_read(t, a);
            finish_read(t, a, $urandom_range(3, 0), 2, 32'h0, 1'b1);
            t = types[$urandom_range(3, 0)];
            a = $urandom;
            do_write(t, a, {$urandom, $urandom, $urandom, $urandom}, 4'($urandom),
                     $urandom_range(3, 0), 1'b1, 1'b0, 32'h0, 1'b0);
        end

        // Reset in the middle of a read burst with a write outstanding
        issue_read(3'b100, 32'h0000_5000);
        arready = 1'b1;
        wr_type = 3'b100; wr_addr = 32'h0000_6000; wr_req = 1'b1;
        tick();
        arready = 1'b0;
        wr_req  = 1'b0;
        rvalid  = 1'b1; rdata = 32'h1111_0000; rlast = 1'b0;
        tick();
        rvalid = 1'b0;
        resetn = 1'b0;
        tick();
        chk("mid_rst_arvalid", arvalid, 1'b0);
        chk("mid_rst_rready", rready, 1'b0);
        chk("mid_rst_awvalid", awvalid, 1'b0);
        chk("mid_rst_wvalid", wvalid, 1'b0);
        chk("mid_rst_bready", bready, 1'b0);
        chk("mid_rst_ret_valid", ret_valid, 1'b0);
        chk("mid_rst_rd_rdy", rd_rdy, 1'b1);
        chk("mid_rst_wr_rdy", wr_rdy, 1'b1);
        resetn = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
